// File: rtl/sram_arbiter.sv
// sram_arbiter: merges the fetch port and the data port onto the SRAM controller's single valid/ready interface.
// Define SRAM_ARB_IBUF_EN to add a one-entry fetch buffer that serves repeated fetches without a memory access.
module sram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_dtr,
    input  logic        d_valid,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dtw,
    output logic        d_ready,
    output logic [31:0] d_dtr,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dtw,
    input  logic        mem_ready,
    input  logic [31:0] mem_dtr
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] dtw;
    } mem_req_t;

    state_e        state_q, state_d;
    port_e         owner_q, owner_d;
    port_e         last_q, last_d;
    port_e         grant_c;
    mem_req_t      req_q, req_d;
    logic          mem_valid_q, mem_valid_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [DW-1:0] i_dtr_q, i_dtr_d;
    logic [DW-1:0] d_dtr_q, d_dtr_d;
    logic          hit_c;

`ifdef SRAM_ARB_IBUF_EN
    logic          ibuf_vld_q, ibuf_vld_d;
    logic [AW-1:0] ibuf_addr_q, ibuf_addr_d;
    logic [DW-1:0] ibuf_data_q, ibuf_data_d;

    assign hit_c = ibuf_vld_q && (i_addr == ibuf_addr_q);
`else
    assign hit_c = 1'b0;
`endif

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        if (i_valid && d_valid) begin
            grant_c = (last_q == PORT_I) ? PORT_D : PORT_I;
        end else if (d_valid) begin
            grant_c = PORT_D;
        end else begin
            grant_c = PORT_I;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        req_d       = req_q;
        mem_valid_d = 1'b0;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_dtr_d     = i_dtr_q;
        d_dtr_d     = d_dtr_q;
`ifdef SRAM_ARB_IBUF_EN
        ibuf_vld_d  = ibuf_vld_q;
        ibuf_addr_d = ibuf_addr_q;
        ibuf_data_d = ibuf_data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_valid || d_valid) begin
                    owner_d = grant_c;
                    last_d  = grant_c;
                    if (grant_c == PORT_I && hit_c) begin
                        state_d   = S_RESP;
                        i_ready_d = 1'b1;
`ifdef SRAM_ARB_IBUF_EN
                        i_dtr_d   = ibuf_data_q;
`endif
                    end else begin
                        state_d     = S_ISSUE;
                        mem_valid_d = 1'b1;
                        if (grant_c == PORT_D) begin
                            req_d = '{rw: d_rw, addr: d_addr, dtw: d_dtw};
                        end else begin
                            req_d = '{rw: 1'b0, addr: i_addr, dtw: '0};
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data is captured for writes as well; the owner sees whatever the controller returns.
                if (mem_ready) begin
                    state_d = S_RESP;
                    if (owner_q == PORT_D) begin
                        d_dtr_d   = mem_dtr;
                        d_ready_d = 1'b1;
                    end else begin
                        i_dtr_d   = mem_dtr;
                        i_ready_d = 1'b1;
`ifdef SRAM_ARB_IBUF_EN
                        ibuf_vld_d  = 1'b1;
                        ibuf_addr_d = req_q.addr;
                        ibuf_data_d = mem_dtr;
`endif
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef SRAM_ARB_IBUF_EN
                if (owner_q == PORT_D && req_q.rw) begin
                    ibuf_vld_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= PORT_I;
            last_q      <= PORT_I;
            req_q       <= '0;
            mem_valid_q <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_dtr_q     <= '0;
            d_dtr_q     <= '0;
`ifdef SRAM_ARB_IBUF_EN
            ibuf_vld_q  <= 1'b0;
            ibuf_addr_q <= '0;
            ibuf_data_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            req_q       <= req_d;
            mem_valid_q <= mem_valid_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_dtr_q     <= i_dtr_d;
            d_dtr_q     <= d_dtr_d;
`ifdef SRAM_ARB_IBUF_EN
            ibuf_vld_q  <= ibuf_vld_d;
            ibuf_addr_q <= ibuf_addr_d;
            ibuf_data_q <= ibuf_data_d;
`endif
        end
    end

    assign i_ready   = i_ready_q;
    assign i_dtr     = i_dtr_q;
    assign d_ready   = d_ready_q;
    assign d_dtr     = d_dtr_q;
    assign mem_valid = mem_valid_q;
    assign mem_rw    = req_q.rw;
    assign mem_addr  = req_q.addr;
    assign mem_dtw   = req_q.dtw;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a memory-backed controller model.
// Honours SRAM_ARB_IBUF_EN to also exercise the fetch buffer.
`timescale 1ns/1ps
module tb_sram_arbiter;

    typedef enum logic {P_I = 1'b0, P_D = 1'b1} port_t;
    typedef struct packed {logic rw; logic [31:0] addr; logic [31:0] dtw;} mreq_t;
    typedef struct {
        bit          ui;
        logic [31:0] ia;
        bit          ud;
        bit          drw;
        logic [31:0] da;
        logic [31:0] dw;
        int          lat;
        port_t       exp_first;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

`ifdef SRAM_ARB_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif

    logic        clk, reset;
    logic        i_valid, i_ready;
    logic [31:0] i_addr, i_dtr;
    logic        d_valid, d_rw, d_ready;
    logic [31:0] d_addr, d_dtw, d_dtr;
    logic        mem_valid, mem_rw, mem_ready;
    logic [31:0] mem_addr, mem_dtw, mem_dtr;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_dtr(i_dtr),
        .d_valid(d_valid), .d_rw(d_rw), .d_addr(d_addr), .d_dtw(d_dtw),
        .d_ready(d_ready), .d_dtr(d_dtr),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dtw(mem_dtw),
        .mem_ready(mem_ready), .mem_dtr(mem_dtr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int i_rdy_cnt = 0, d_rdy_cnt = 0, mv_cnt = 0;
    int ctrl_lat = 3;
    bit inject_spur = 1'b0;
    mreq_t mem_log[$];
    logic [31:0] mem_model [logic [31:0]];

    // Reference state: who was served last and what the fetch buffer should hold.
    port_t       last_m;
    bit          ib_vld_m;
    logic [31:0] ib_addr_m, ib_data_m;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Controller model: a plain memory answering after ctrl_lat cycles, returning old contents on writes.
    task automatic ctrl_loop();
        bit          busy;
        int          cnt;
        mreq_t       hold;
        logic [31:0] resp;
        busy = 1'b0; cnt = 0; hold = '0; resp = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (reset !== 1'b1) begin
                busy = 1'b0;
                continue;
            end
            if (mem_valid === 1'b1) begin
                chk("mem_valid_while_busy", 32'(busy), 32'd0);
                hold = '{rw: mem_rw, addr: mem_addr, dtw: mem_dtw};
                mem_log.push_back(hold);
                mv_cnt++;
                resp = mem_peek(mem_addr);
                if (mem_rw) mem_model[mem_addr] = mem_dtw;
                busy = 1'b1;
                cnt = ctrl_lat;
            end else if (busy) begin
                chk("mem_rw_stable", 32'(mem_rw), 32'(hold.rw));
                chk("mem_addr_stable", mem_addr, hold.addr);
                chk("mem_dtw_stable", mem_dtw, hold.dtw);
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_dtr = resp;
                    busy = 1'b0;
                end
            end else if (inject_spur) begin
                mem_ready = 1'b1;
                mem_dtr = 32'hBAD0_BAD0;
            end
        end
    endtask

    task automatic mon_loop();
        forever begin
            @(posedge clk);
            #1;
            if (i_ready === 1'b1) i_rdy_cnt++;
            if (d_ready === 1'b1) d_rdy_cnt++;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        last_m = P_I; ib_vld_m = 1'b0;
    endtask

    // One request (or a simultaneous pair), checked against the arbitration/memory reference.
    task automatic serve(input bit ui, input logic [31:0] ia, input bit ud, input bit drw,
                         input logic [31:0] da, input logic [31:0] dw, input int lat,
                         output port_t first, output logic [31:0] got_i, output logic [31:0] got_d);
        port_t       order[2];
        bit          hit[2];
        int          n, ik, i0, d0, mv0, base;
        bit          i_done, d_done, mr_prev, have_first;
        logic [31:0] exp_i, exp_d, i_dtr0, d_dtr0;
        mreq_t       exp_req[$];
        mreq_t       r;
        n = (ui && ud) ? 2 : 1;
        order[0] = (ui && ud) ? ((last_m == P_I) ? P_D : P_I) : (ud ? P_D : P_I);
        order[1] = (order[0] == P_I) ? P_D : P_I;
        ik = (order[0] == P_I) ? 0 : 1;
        exp_i = '0; exp_d = '0;
        for (int k = 0; k < n; k++) begin
            hit[k] = 1'b0;
            if (order[k] == P_I) begin
                if (IBUF && ib_vld_m && ia == ib_addr_m) begin
                    hit[k] = 1'b1;
                    exp_i = ib_data_m;
                end else begin
                    exp_i = (k == 1 && drw && da == ia) ? dw : mem_peek(ia);
                    exp_req.push_back('{rw: 1'b0, addr: ia, dtw: 32'h0});
                    ib_vld_m = 1'b1; ib_addr_m = ia; ib_data_m = exp_i;
                end
            end else begin
                exp_d = mem_peek(da);
                exp_req.push_back('{rw: drw, addr: da, dtw: dw});
                if (drw) ib_vld_m = 1'b0;
            end
        end
        last_m = order[n-1];

        ctrl_lat = lat;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; mv0 = mv_cnt; base = mem_log.size();
        i_dtr0 = i_dtr; d_dtr0 = d_dtr;
        i_valid = ui; i_addr = ia; d_valid = ud; d_rw = drw; d_addr = da; d_dtw = dw;
        i_done = !ui; d_done = !ud; have_first = 1'b0; first = order[0];
        got_i = '0; got_d = '0; mr_prev = 1'b0;
        for (int cyc = 0; cyc < 200 && !(i_done && d_done); cyc++) begin
            tick();
            if (cyc == 0) chk("mem_valid_after_grant", 32'(mem_valid), 32'(!hit[0]));
            if (i_ready === 1'b1 && !i_done) begin
                i_done = 1'b1; i_valid = 1'b0; got_i = i_dtr;
                if (!have_first) begin first = P_I; have_first = 1'b1; end
                if (!hit[ik]) chk("i_ready_after_mem_ready", 32'(mr_prev), 32'd1);
                else if (ik == 0) chk("ibuf_hit_latency", 32'(cyc), 32'd0);
            end
            if (d_ready === 1'b1 && !d_done) begin
                d_done = 1'b1; d_valid = 1'b0; got_d = d_dtr;
                if (!have_first) begin first = P_D; have_first = 1'b1; end
                chk("d_ready_after_mem_ready", 32'(mr_prev), 32'd1);
            end
            mr_prev = mem_ready;
        end
        if (!(i_done && d_done)) begin
            checks++; errors++;
            $display("FAIL serve_timeout: i_done=%0d d_done=%0d, required both 1", i_done, d_done);
        end
        i_valid = 1'b0; d_valid = 1'b0;
        repeat (3) tick();
        chk("i_ready_pulses", 32'(i_rdy_cnt - i0), 32'(ui));
        chk("d_ready_pulses", 32'(d_rdy_cnt - d0), 32'(ud));
        chk("mem_valid_pulses", 32'(mv_cnt - mv0), 32'(exp_req.size()));
        chk("grant_order", 32'(first), 32'(order[0]));
        if (ui) chk("i_dtr", got_i, exp_i); else chk("i_dtr_hold", i_dtr, i_dtr0);
        if (ud) chk("d_dtr", got_d, exp_d); else chk("d_dtr_hold", d_dtr, d_dtr0);
        for (int k = 0; k < exp_req.size() && base + k < mem_log.size(); k++) begin
            r = mem_log[base + k];
            chk("mem_rw", 32'(r.rw), 32'(exp_req[k].rw));
            chk("mem_addr", r.addr, exp_req[k].addr);
            if (exp_req[k].rw) chk("mem_dtw", r.dtw, exp_req[k].dtw);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[9];
        port_t       first;
        logic [31:0] gi, gd;
        int          i0, d0, mv0, ni, nd, sel;
        string       order_s;

        reset = 1'b0; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_rw = 1'b0;
        d_addr = '0; d_dtw = '0; mem_ready = 1'b0; mem_dtr = '0;
        last_m = P_I; ib_vld_m = 1'b0; ib_addr_m = '0; ib_data_m = '0;
        fork
            ctrl_loop();
            mon_loop();
        join_none

        vecs[0] = '{1, 32'h100, 0, 0, 32'h0,   32'h0,        4, P_I, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 32'h0,   1, 1, 32'h201, 32'h11223344, 3, P_D, 32'h0,        32'hA5A50201};
        vecs[2] = '{0, 32'h0,   1, 0, 32'h201, 32'h0,        2, P_D, 32'h0,        32'h11223344};
        vecs[3] = '{1, 32'h104, 1, 0, 32'h300, 32'h0,        1, P_I, 32'hA5A50104, 32'hA5A50300};
        vecs[4] = '{1, 32'h108, 1, 1, 32'h400, 32'hCAFEF00D, 5, P_I, 32'hA5A50108, 32'hA5A50400};
        vecs[5] = '{0, 32'h0,   1, 0, 32'h400, 32'h0,        1, P_D, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{1, 32'h10C, 0, 0, 32'h0,   32'h0,        2, P_I, 32'hA5A5010C, 32'h0};
        vecs[7] = '{1, 32'h100, 1, 0, 32'h201, 32'h0,        3, P_D, 32'hDEADBEEF, 32'h11223344};
        vecs[8] = '{1, 32'h110, 1, 1, 32'h108, 32'h55AA55AA, 2, P_D, 32'hA5A50110, 32'hA5A50108};
        mem_model[32'h100] = 32'hDEADBEEF;

        tick(); tick();
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            serve(vecs[v].ui, vecs[v].ia, vecs[v].ud, vecs[v].drw, vecs[v].da, vecs[v].dw,
                  vecs[v].lat, first, gi, gd);
            chk($sformatf("vec%0d_first", v), 32'(first), 32'(vecs[v].exp_first));
            if (vecs[v].ui) chk($sformatf("vec%0d_i_dtr", v), gi, vecs[v].exp_i);
            if (vecs[v].ud) chk($sformatf("vec%0d_d_dtr", v), gd, vecs[v].exp_d);
        end

        // Stray controller ready while idle must be ignored.
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; mv0 = mv_cnt;
        inject_spur = 1'b1;
        tick();
        inject_spur = 1'b0;
        repeat (4) tick();
        chk("spur_i_ready", 32'(i_rdy_cnt - i0), 32'd0);
        chk("spur_d_ready", 32'(d_rdy_cnt - d0), 32'd0);
        chk("spur_mem_valid", 32'(mv_cnt - mv0), 32'd0);
        serve(1, 32'h114, 0, 0, 32'h0, 32'h0, 2, first, gi, gd);

        // Both ports held from reset and re-requested: grants must alternate starting with D.
        reset = 1'b0;
        i_valid = 1'b1; i_addr = 32'h3000; d_valid = 1'b1; d_rw = 1'b0; d_addr = 32'h3100;
        ctrl_lat = 2;
        tick();
        reset = 1'b1;
        ni = 0; nd = 0; order_s = "";
        for (int cyc = 0; cyc < 400 && (ni < 3 || nd < 3); cyc++) begin
            tick();
            if (i_ready === 1'b1) begin
                order_s = {order_s, "I"}; ni++; i_valid = 1'b0; i_addr = i_addr + 32'd4;
            end else if (ni < 3 && !i_valid) begin
                i_valid = 1'b1;
            end
            if (d_ready === 1'b1) begin
                order_s = {order_s, "D"}; nd++; d_valid = 1'b0; d_addr = d_addr + 32'd4;
            end else if (nd < 3 && !d_valid) begin
                d_valid = 1'b1;
            end
        end
        checks++;
        if (order_s != "DIDIDI") begin
            errors++;
            $display("FAIL grant_alternation: got %s, expected DIDIDI", order_s);
        end
        i_valid = 1'b0; d_valid = 1'b0;
        reset_dut();

        // Reset while waiting on the controller aborts silently.
        ctrl_lat = 10;
        i_valid = 1'b1; i_addr = 32'h500;
        repeat (3) tick();
        reset = 1'b0; i_valid = 1'b0;
        #1;
        chk("abort_i_ready", 32'(i_ready), 32'd0);
        chk("abort_i_dtr", i_dtr, 32'd0);
        chk("abort_d_dtr", d_dtr, 32'd0);
        chk("abort_mem_valid", 32'(mem_valid), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_rw", 32'(mem_rw), 32'd0);
        tick(); tick();
        reset = 1'b1;
        last_m = P_I; ib_vld_m = 1'b0;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; mv0 = mv_cnt;
        repeat (12) tick();
        chk("abort_no_i_ready", 32'(i_rdy_cnt - i0), 32'd0);
        chk("abort_no_d_ready", 32'(d_rdy_cnt - d0), 32'd0);
        chk("abort_no_mem_valid", 32'(mv_cnt - mv0), 32'd0);
        serve(1, 32'h504, 0, 0, 32'h0, 32'h0, 3, first, gi, gd);
        chk("post_abort_fetch", gi, 32'hA5A50504);

`ifdef SRAM_ARB_IBUF_EN
        reset_dut();
        serve(1, 32'h40, 0, 0, 32'h0, 32'h0, 3, first, gi, gd);
        mv0 = mv_cnt;
        serve(1, 32'h40, 0, 0, 32'h0, 32'h0, 3, first, gi, gd);
        chk("ibuf_hit_no_mem", 32'(mv_cnt - mv0), 32'd0);
        chk("ibuf_hit_data", gi, 32'hA5A50040);
        serve(0, 32'h0, 1, 1, 32'h80, 32'h12345678, 2, first, gi, gd);
        mv0 = mv_cnt;
        serve(1, 32'h40, 0, 0, 32'h0, 32'h0, 3, first, gi, gd);
        chk("ibuf_cleared_by_write", 32'(mv_cnt - mv0), 32'd1);
`endif

        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(1, 3));
            serve(sel % 2 == 1, 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4,
                  sel >= 2, 1'($urandom_range(0, 1)),
                  32'h2000 + 32'($urandom_range(0, 15)) * 32'd4, 32'($urandom),
                  int'($urandom_range(1, 6)), first, gi, gd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
